// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared constants and state encoding for the serial flash read path
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam int         CMD_BITS = 32;
    localparam int         BYTE_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/spi_flash_rd_seq.sv
// rtl/spi_flash_rd_seq.sv - read-transaction sequencer driving the flash SPI clock generator
module spi_flash_rd_seq #(
    parameter int         LEN_W    = 8,
    parameter logic [7:0] CMD_READ = 8'h03,
    parameter int         CS_IDLE  = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             req,
    input  logic [23:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             clg_go,
    output logic             clg_enable,
    output logic             clg_last_clk,
    input  logic             clg_pos_edge,
    input  logic             clg_neg_edge,
    output logic             ss_n,
    output logic             mosi,
    input  logic             miso
);
    import spi_flash_pkg::*;

    localparam int CNT_W  = LEN_W + 4;
    localparam int HOLD_W = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

    state_t              state_q;
    state_t              state_d;
    logic [31:0]         tx_q;
    logic [BYTE_W-1:0]   rx_q;
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [CNT_W-1:0]    total_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic                last_q;
    logic                abt_q;
    logic                done_q;
    logic                aborted_q;
    logic [BYTE_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic                mosi_q;

    logic                accept;
    logic                read_phase;
    logic                byte_end;
    logic                final_rise;
    logic                hold_end;
    logic [BYTE_W-1:0]   rx_next;

    // A done pulse blocks acceptance so the earliest restart is the cycle after done
    assign accept     = (state_q == IDLE) && req && !done_q;
    assign read_phase = bit_cnt_q >= CNT_W'(CMD_BITS);
    // Read phase starts on a byte boundary, so the low bits index the bit within the byte
    assign byte_end   = read_phase && (bit_cnt_q[2:0] == 3'd7);
    assign final_rise = clg_pos_edge && ((bit_cnt_q + CNT_W'(1)) == total_q);
    assign hold_end   = hold_cnt_q == HOLD_W'(CS_IDLE - 1);
    assign rx_next    = {rx_q[BYTE_W-2:0], miso};

    // State register
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort from any active state forces the chip-select hold
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = abort ? HOLD : XFER;
            XFER:    if (abort || (clg_neg_edge && last_q)) state_d = HOLD;
            HOLD:    if (!abort && hold_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs; ss_n follows the async-reset state register
    always_comb begin
        busy         = state_q != IDLE;
        ss_n         = !((state_q == SETUP) || (state_q == XFER));
        clg_go       = state_q == SETUP;
        clg_enable   = state_q == XFER;
        clg_last_clk = (state_q == XFER) && last_q;
    end

    // Shift registers, bit counting, byte delivery and completion reporting
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tx_q       <= '0;
            rx_q       <= '0;
            bit_cnt_q  <= '0;
            total_q    <= '0;
            hold_cnt_q <= '0;
            last_q     <= 1'b0;
            abt_q      <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        tx_q       <= {CMD_READ, req_addr};
                        mosi_q     <= CMD_READ[7];
                        total_q    <= CNT_W'(CMD_BITS) + ((CNT_W'(req_len) + CNT_W'(1)) << 3);
                        bit_cnt_q  <= '0;
                        rx_q       <= '0;
                        last_q     <= 1'b0;
                        abt_q      <= 1'b0;
                        hold_cnt_q <= '0;
                    end
                end
                XFER: begin
                    if (clg_pos_edge) begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (read_phase) rx_q <= rx_next;
                        if (byte_end) begin
                            rd_data_q  <= rx_next;
                            rd_valid_q <= 1'b1;
                        end
                        if (final_rise) last_q <= 1'b1;
                    end
                    if (clg_neg_edge) begin
                        if (!read_phase) begin
                            tx_q   <= {tx_q[30:0], 1'b0};
                            mosi_q <= tx_q[30];
                        end else begin
                            mosi_q <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    mosi_q     <= 1'b0;
                    last_q     <= 1'b0;
                    if (state_d == IDLE) begin
                        done_q    <= 1'b1;
                        aborted_q <= abt_q;
                    end
                end
                default: ;
            endcase
            // Abort restarts the chip-select hold and marks the outcome
            if (abort && (state_q != IDLE)) begin
                abt_q      <= 1'b1;
                hold_cnt_q <= '0;
            end
        end
    end

    assign done     = done_q;
    assign aborted  = aborted_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// tb/tb_spi_flash_rd_seq.sv - scoreboard bench for spi_flash_rd_seq with clock-generator and flash models
module tb_spi_flash_rd_seq;

    localparam int CS_IDLE = 2;
    localparam int DIV     = 2;

    logic        clk_in;
    logic        rst;
    logic        req;
    logic [23:0] req_addr;
    logic [7:0]  req_len;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        clg_go;
    logic        clg_enable;
    logic        clg_last_clk;
    logic        clg_pos_edge;
    logic        clg_neg_edge;
    logic        ss_n;
    logic        mosi;
    logic        miso;

    spi_flash_rd_seq #(.LEN_W(8), .CMD_READ(8'h03), .CS_IDLE(CS_IDLE)) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .req          (req),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .clg_go       (clg_go),
        .clg_enable   (clg_enable),
        .clg_last_clk (clg_last_clk),
        .clg_pos_edge (clg_pos_edge),
        .clg_neg_edge (clg_neg_edge),
        .ss_n         (ss_n),
        .mosi         (mosi),
        .miso         (miso)
    );

    typedef struct {
        logic [31:0] hdr;
        int          total;
        bit          aborted;
    } txn_t;

    txn_t        txn_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  slave_mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    int          mon_rises;
    logic [31:0] mon_hdr;
    logic        mon_sck_prev;
    logic        mon_ss_prev;
    int          gap;
    bit          have_gap;
    int          ss_falls;
    int          n_valid;

    logic        sck;
    logic        phase;
    int          div_cnt;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Clock generator model: alternating pos/neg pulses every DIV cycles while enabled
    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            clg_pos_edge <= 1'b0;
            clg_neg_edge <= 1'b0;
            sck          <= 1'b0;
            phase        <= 1'b0;
            div_cnt      <= 0;
        end else begin
            clg_pos_edge <= 1'b0;
            clg_neg_edge <= 1'b0;
            if (clg_pos_edge) sck <= 1'b1;
            if (clg_neg_edge) sck <= 1'b0;
            if (clg_go) sck <= 1'b0;
            if (!clg_enable) begin
                div_cnt <= 0;
                phase   <= 1'b0;
            end else if (div_cnt == DIV - 1) begin
                div_cnt <= 0;
                phase   <= ~phase;
                if (!phase) clg_pos_edge <= 1'b1;
                else        clg_neg_edge <= 1'b1;
            end else begin
                div_cnt <= div_cnt + 1;
            end
        end
    end

    // Flash model: after 32 rises, shifts slave_mem out MSB first on each SCK fall
    initial begin : flash_model
        int   s_rises;
        int   idx;
        logic s_sck_prev;
        s_rises    = 0;
        s_sck_prev = 1'b0;
        miso       = 1'b0;
        forever begin
            @(sck or ss_n);
            if (ss_n === 1'b1) begin
                s_rises = 0;
            end else if (sck && !s_sck_prev) begin
                s_rises++;
            end else if (!sck && s_sck_prev && s_rises >= 32) begin
                idx = s_rises - 32;
                if (idx < 2048) miso = slave_mem[idx / 8][7 - (idx % 8)];
            end
            s_sck_prev = sck;
        end
    end

    // Monitor: header capture, SCK rise count, ss_n gap, byte and completion scoreboard
    always @(negedge clk_in) begin
        if (rst) begin
            mon_rises    = 0;
            mon_hdr      = '0;
            mon_sck_prev = 1'b0;
            mon_ss_prev  = 1'b1;
            gap          = 0;
            have_gap     = 0;
            ss_falls     = 0;
        end else begin
            if (!ss_n && mon_ss_prev) begin
                if (have_gap) check("ss_gap_ge_cs_idle", 32'(gap >= CS_IDLE), 1);
                mon_rises = 0;
                mon_hdr   = '0;
                ss_falls++;
            end
            if (ss_n && !mon_ss_prev) begin
                have_gap = 1;
                gap      = 0;
            end
            if (ss_n) gap++;
            mon_ss_prev = ss_n;
            if (sck && !mon_sck_prev) begin
                if (mon_rises < 32) mon_hdr = {mon_hdr[30:0], mosi};
                mon_rises++;
            end
            mon_sck_prev = sck;
            if (rd_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    check("unexpected_rd_valid", {24'h0, rd_data}, 32'hFFFF_FFFF);
                end else begin
                    check("rd_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
                end
            end
            if (done) begin
                if (txn_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 0);
                end else begin
                    txn_t t;
                    t = txn_q.pop_front();
                    check("aborted_flag", 32'(aborted), 32'(t.aborted));
                    check("last_clk_low_at_done", 32'(clg_last_clk), 0);
                    if (!t.aborted) begin
                        check("sck_rises", mon_rises, t.total);
                        check("mosi_header", mon_hdr, t.hdr);
                        check("sck_ends_low", 32'(sck), 0);
                        check("single_cs_window", ss_falls, 1);
                    end
                end
                ss_falls = 0;
            end
        end
    end

    task automatic do_req(input logic [23:0] a, input logic [7:0] l, input bit exp_abort, input bit with_abort);
        txn_t t;
        t.hdr     = {8'h03, a};
        t.total   = 32 + 8 * (int'(l) + 1);
        t.aborted = exp_abort;
        txn_q.push_back(t);
        if (!exp_abort) begin
            for (int i = 0; i <= int'(l); i++) exp_q.push_back(slave_mem[i]);
        end
        @(posedge clk_in); #1;
        req      = 1'b1;
        req_addr = a;
        req_len  = l;
        abort    = with_abort;
        @(posedge clk_in); #1;
        req   = 1'b0;
        abort = 1'b0;
        check("accept_busy", 32'(busy), 1);
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 12000 && !seen; i++) begin
            @(negedge clk_in);
            if (done) seen = 1;
        end
        if (!seen) check({nm, "_done_timeout"}, 0, 1);
    endtask

    task automatic wait_rises(input int n, input string nm);
        bit seen;
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(posedge clk_in); #1;
            if (mon_rises >= n) seen = 1;
        end
        if (!seen) check({nm, "_rise_timeout"}, 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        req      = 1'b0;
        req_addr = '0;
        req_len  = '0;
        abort    = 1'b0;
        n_valid  = 0;
        for (int i = 0; i < 256; i++) slave_mem[i] = 8'h00;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_busy",     32'(busy), 0);
        check("rst_done",     32'(done), 0);
        check("rst_aborted",  32'(aborted), 0);
        check("rst_rd_data",  {24'h0, rd_data}, 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_go",       32'(clg_go), 0);
        check("rst_enable",   32'(clg_enable), 0);
        check("rst_last_clk", 32'(clg_last_clk), 0);
        check("rst_ss_n",     32'(ss_n), 1);
        check("rst_mosi",     32'(mosi), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk_in);

        // Single byte read
        slave_mem[0] = 8'hA5;
        do_req(24'h123456, 8'd0, 0, 0);
        wait_done("t1");

        // Four bytes, with an ignored req while busy
        slave_mem[0] = 8'hDE; slave_mem[1] = 8'hAD;
        slave_mem[2] = 8'hBE; slave_mem[3] = 8'hEF;
        do_req(24'hFEDCBA, 8'd3, 0, 0);
        repeat (30) @(posedge clk_in);
        #1;
        req = 1'b1; req_addr = 24'h000777; req_len = 8'd5;
        @(posedge clk_in); #1;
        req = 1'b0;
        wait_done("t2");

        // Back-to-back on the cycle after done, with abort in the same IDLE cycle as req
        slave_mem[0] = 8'h3C; slave_mem[1] = 8'hC3;
        do_req(24'hABCDEF, 8'd1, 0, 1);
        wait_done("t3");

        // Abort during the header
        do_req(24'h000100, 8'd3, 1, 0);
        wait_rises(20, "t4");
        abort = 1'b1;
        @(posedge clk_in); #1;
        abort = 1'b0;
        check("abort_ss_n",   32'(ss_n), 1);
        check("abort_enable", 32'(clg_enable), 0);
        wait_done("t4");

        // Reset in the read phase
        slave_mem[0] = 8'h11; slave_mem[1] = 8'h22;
        slave_mem[2] = 8'h33; slave_mem[3] = 8'h44;
        do_req(24'h0F0F0F, 8'd3, 0, 0);
        wait_rises(44, "t5");
        rst = 1'b1;
        #1;
        check("rst_mid_ss_n",   32'(ss_n), 1);
        check("rst_mid_busy",   32'(busy), 0);
        check("rst_mid_enable", 32'(clg_enable), 0);
        txn_q.delete();
        exp_q.delete();
        repeat (3) @(posedge clk_in);
        #1;
        rst = 1'b0;

        // Full-length read: 256 bytes, 2080 bits
        for (int i = 0; i < 256; i++) slave_mem[i] = 8'(i * 37 + 11);
        n_valid = 0;
        do_req(24'h000000, 8'hFF, 0, 0);
        wait_done("t6");
        check("t6_byte_count", n_valid, 256);

        repeat (4) @(posedge clk_in);
        check("txn_q_empty", txn_q.size(), 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
